se_channel_scale: RTL
=====================

SE_CHANNEL_SCALE -- requirements
Module: se_channel_scale

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, signed fixed-point word width.
REQ-002 SHALL have parameter FBITS, default 7, fractional bits of every fixed-point word.
REQ-003 SHALL have parameter LANES, default 7, elements per feature-map beat.
REQ-004 SHALL have parameter MAX_CH, default 576, excitation buffer depth.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: async active-high reset.
- start, in, 1: one-cycle launch pulse.
- num_channels, in, 10: channel count, 1..MAX_CH.
- row_start, in, 2: first row index.
- final_row, in, 6: last row index, inclusive.
- col_last, in, 3: last column-beat index, inclusive.
- exc_valid, in, 1: excitation beat valid.
- exc_data, in, DATA_WIDTH: signed FC2 output, one per channel, in channel order.
- data_in, in, LANES*DATA_WIDTH: read data, valid 1 cycle after rd_en.
- rd_en, out, 1: feature-map read strobe.
- R_Ch_addr, out, 10: read channel address.
- R_Row_addr, out, 6: read row address.
- R_Col_addr, out, 3: read column address.
- wr_en, out, 1: scaled-beat write strobe.
- W_Ch_addr, out, 10: write channel address.
- W_Row_addr, out, 6: write row address.
- W_Col_addr, out, 3: write column address.
- Final_Data, out, LANES*DATA_WIDTH: scaled beat; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- busy, out, 1: high whenever the FSM is not in IDLE.
- done, out, 1: one-cycle completion pulse.

Function
REQ-007 FSM states: IDLE, LOAD, SCAN, DRAIN.
REQ-008 IDLE->LOAD on start with num_channels!=0; latch num_channels, row_start, final_row, col_last; clear the channel counter.
REQ-009 start with num_channels==0, or start while busy: ignored, no state change.
REQ-010 LOAD: each exc_valid beat stores hsig(exc_data) at buffer[count], count+1; after beat num_channels-1 -> SCAN next cycle.
REQ-011 exc_valid outside LOAD: ignored.
REQ-012 hsig: t = clamp(x + (3<<FBITS), 0, 6<<FBITS); s = floor((t+3)/6); s range 0..(1<<FBITS).
REQ-013 SCAN: one rd_en per cycle; nested loop, channel outer 0..num_channels-1, row middle row_start..final_row, column inner 0..col_last.
REQ-014 final_row<row_start: exactly one row (row_start) per channel.
REQ-015 After the last address issues -> DRAIN for 2 cycles -> IDLE, with done high on the last DRAIN cycle.
REQ-016 Pipeline: read issued at cycle n; data_in sampled at n+1; wr_en, Final_Data and W_* addresses registered at n+2 (latency 2), with W_* equal to the R_* values of cycle n.
REQ-017 Lane arithmetic: Final_Data lane = (data lane * s) >>> FBITS, using a full-precision signed product and arithmetic shift (floor); since |s|<=1.0 the result always fits DATA_WIDTH with no saturation.
REQ-018 rd_en and wr_en are low except as stated above; address outputs hold their last value when not strobed.

Reset
REQ-019 rst SHALL force IDLE asynchronously, at any time including mid-SCAN or mid-DRAIN.
REQ-020 Reset values: busy=0, done=0, rd_en=0, wr_en=0, all addresses 0, Final_Data 0, count 0, buffer contents 0.
REQ-021 In-flight pipeline writes are discarded on reset.

Verification
REQ-022 exc_data=0, data lanes=128 (1.0) -> s=64, every lane of Final_Data = 64.
REQ-023 exc_data=-512 (-4.0), lanes=300 -> lanes 0; exc_data=640 (5.0), lanes=-77 -> lanes -77 (s=128).
REQ-024 s=64, lane=-128 -> -64; lane=-1 -> -1 (floor).
REQ-025 num_channels=2, row_start=1, final_row=2, col_last=1 -> 8 reads in order (ch,row,col): (0,1,0),(0,1,1),(0,2,0),(0,2,1),(1,1,0),(1,1,1),(1,2,0),(1,2,1); each write 2 cycles after its read; done 2 cycles after the last read; busy falls with done.
REQ-026 rst asserted on the 3rd SCAN cycle -> next edge busy=0, rd_en=0, wr_en=0; a fresh start then runs the full sequence correctly.
REQ-027 start during SCAN, and exc_valid in IDLE -> no effect on the sequence or the buffer.

Source files
------------

// File: rtl/se_channel_scale.sv
// se_channel_scale: squeeze-excitation channel rescale.
// Loads one hard-sigmoid excitation per channel, then streams every feature-map
// beat of the selected rows/columns through a 2-cycle multiply pipeline.
module se_channel_scale #(
  parameter int DATA_WIDTH = 14,
  parameter int FBITS      = 7,
  parameter int LANES      = 7,
  parameter int MAX_CH     = 576
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [9:0]                        num_channels,
  input  logic [1:0]                        row_start,
  input  logic [5:0]                        final_row,
  input  logic [2:0]                        col_last,
  input  logic                              exc_valid,
  input  logic signed [DATA_WIDTH-1:0]      exc_data,
  input  logic [LANES*DATA_WIDTH-1:0]       data_in,
  output logic                              rd_en,
  output logic [9:0]                        R_Ch_addr,
  output logic [5:0]                        R_Row_addr,
  output logic [2:0]                        R_Col_addr,
  output logic                              wr_en,
  output logic [9:0]                        W_Ch_addr,
  output logic [5:0]                        W_Row_addr,
  output logic [2:0]                        W_Col_addr,
  output logic [LANES*DATA_WIDTH-1:0]       Final_Data,
  output logic                              busy,
  output logic                              done
);

  // Scale factor width: 0..(1<<FBITS) plus a zero sign bit.
  localparam int SW = FBITS + 2;
  // Headroom for x + 3.0 before clamping.
  localparam int TW = DATA_WIDTH + 4;
  localparam logic signed [TW-1:0] C3 = TW'(3 << FBITS);
  localparam logic signed [TW-1:0] C6 = TW'(6 << FBITS);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DRAIN} state_t;

  state_t                        r_state;
  logic [9:0]                    r_num;
  logic [9:0]                    r_count;
  logic [1:0]                    r_row_start;
  logic [5:0]                    r_final_row;
  logic [2:0]                    r_col_last;
  logic [9:0]                    r_ch;
  logic [5:0]                    r_row;
  logic [2:0]                    r_col;
  logic                          r_drain;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_rd_en;
  logic [9:0]                    r_rch;
  logic [5:0]                    r_rrow;
  logic [2:0]                    r_rcol;
  logic signed [SW-1:0]          r_buf [0:MAX_CH-1];
  logic                          r_rd_d1;
  logic [9:0]                    r_ch_d1;
  logic [5:0]                    r_row_d1;
  logic [2:0]                    r_col_d1;
  logic signed [SW-1:0]          r_scale;
  logic                          r_wr_en;
  logic [9:0]                    r_wch;
  logic [5:0]                    r_wrow;
  logic [2:0]                    r_wcol;
  logic [LANES*DATA_WIDTH-1:0]   r_final;

  logic                          w_col_end;
  logic                          w_row_end;
  logic                          w_ch_end;
  logic                          w_load_end;
  logic [5:0]                    w_row_first;
  logic [LANES*DATA_WIDTH-1:0]   w_scaled;

  // Hard sigmoid: clamp(x + 3, 0, 6) / 6, floored, in FBITS fixed point.
  function automatic logic signed [SW-1:0] hsig(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [TW-1:0] t;
    logic signed [TW-1:0] q;
    t = TW'(x) + C3;
    if (t < 0)
      t = '0;
    else if (t > C6)
      t = C6;
    q = (t + TW'(3)) / TW'(6);
    return SW'(q);
  endfunction

  assign w_row_first = {4'b0000, r_row_start};
  assign w_col_end   = (r_col == r_col_last);
  // A final row below the start row still yields exactly the start row.
  assign w_row_end   = (r_row >= r_final_row);
  assign w_ch_end    = (r_ch == r_num - 10'd1);
  assign w_load_end  = (r_count == r_num - 10'd1);

  // Control FSM: launch, excitation load, address scan, pipeline drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_num       <= '0;
      r_count     <= '0;
      r_row_start <= '0;
      r_final_row <= '0;
      r_col_last  <= '0;
      r_ch        <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_drain     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rch       <= '0;
      r_rrow      <= '0;
      r_rcol      <= '0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && num_channels != 10'd0) begin
            r_state     <= LOAD;
            r_busy      <= 1'b1;
            r_num       <= num_channels;
            r_row_start <= row_start;
            r_final_row <= final_row;
            r_col_last  <= col_last;
            r_count     <= '0;
          end
        end
        LOAD: begin
          if (exc_valid) begin
            r_count <= r_count + 10'd1;
            if (w_load_end) begin
              r_state <= SCAN;
              r_ch    <= '0;
              r_row   <= w_row_first;
              r_col   <= '0;
            end
          end
        end
        SCAN: begin
          r_rd_en <= 1'b1;
          r_rch   <= r_ch;
          r_rrow  <= r_row;
          r_rcol  <= r_col;
          if (!w_col_end) begin
            r_col <= r_col + 3'd1;
          end else begin
            r_col <= '0;
            if (!w_row_end) begin
              r_row <= r_row + 6'd1;
            end else begin
              r_row <= w_row_first;
              if (w_ch_end) begin
                r_state <= DRAIN;
                r_drain <= 1'b0;
              end else begin
                r_ch <= r_ch + 10'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (r_drain) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Excitation buffer: written only while loading, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_CH; i++) r_buf[i] <= '0;
    end else if (r_state == LOAD && exc_valid && int'(r_count) < MAX_CH) begin
      r_buf[r_count] <= hsig(exc_data);
    end
  end

  // Per-lane full-precision product, arithmetic shift back to FBITS.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [DATA_WIDTH-1:0]    w_lane;
    logic signed [DATA_WIDTH+SW-1:0] w_prod;
    assign w_lane = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod = w_lane * r_scale;
    assign w_scaled[gi*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_prod >>> FBITS);
  end

  // Two-stage write pipeline: scale/address capture, then scaled beat out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_d1  <= 1'b0;
      r_ch_d1  <= '0;
      r_row_d1 <= '0;
      r_col_d1 <= '0;
      r_scale  <= '0;
      r_wr_en  <= 1'b0;
      r_wch    <= '0;
      r_wrow   <= '0;
      r_wcol   <= '0;
      r_final  <= '0;
    end else begin
      r_rd_d1 <= r_rd_en;
      r_wr_en <= r_rd_d1;
      if (r_rd_en) begin
        r_ch_d1  <= r_rch;
        r_row_d1 <= r_rrow;
        r_col_d1 <= r_rcol;
        r_scale  <= r_buf[r_rch];
      end
      if (r_rd_d1) begin
        r_wch   <= r_ch_d1;
        r_wrow  <= r_row_d1;
        r_wcol  <= r_col_d1;
        r_final <= w_scaled;
      end
    end
  end

  assign rd_en      = r_rd_en;
  assign R_Ch_addr  = r_rch;
  assign R_Row_addr = r_rrow;
  assign R_Col_addr = r_rcol;
  assign wr_en      = r_wr_en;
  assign W_Ch_addr  = r_wch;
  assign W_Row_addr = r_wrow;
  assign W_Col_addr = r_wcol;
  assign Final_Data = r_final;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
